// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS core.
// Decodes the IR opcode and funct fields and sequences every datapath strobe.
// Also runs the memory wait handshake and counts retired instructions.
// Outputs are decoded from the registered state; pc_en and ir_write in FETCH,
// and pc_en in BEQ, also follow live inputs. The async reset forces every
// output to its default immediately, so an aborted write never lingers.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Twelve live states; the four spare encodings fall back to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BEQ     = 4'd8,
        S_IMM_EX  = 4'd9,
        S_IMM_WB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       r_alu;
    logic             r_legal;

    // R-type funct decode; unknown functs run as ADD but never write back.
    always_comb begin
        r_alu   = ALU_ADD;
        r_legal = 1'b1;
        case (funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            default:   r_legal = 1'b0;
        endcase
    end

    // Next-state selection and retire counting (one retire per return to FETCH).
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:         state_d = S_R_EX;
                    OP_LW, OP_SW:     state_d = S_MEM_ADR;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_ADDI, OP_SLTI: state_d = S_IMM_EX;
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:    state_d = S_R_WB;
            S_IMM_EX:  state_d = S_IMM_WB;
            default:   state_d = S_FETCH;
        endcase
        count_d = count_q;
        if (state_q != S_FETCH && state_d == S_FETCH)
            count_d = count_q + 1'b1;
    end

    // State and retire counter registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Datapath strobes decoded from state, held at defaults while reset is low.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_ADD;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEM_ADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EX: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = r_alu;
                end
                S_R_WB: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = r_alu;
                    reg_dst   = 1'b1;
                    reg_write = r_legal;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_en     = zero;
                end
                S_IMM_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IMM_WB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle strobes, and a compare process checks
// every cycle. A second instance with a 4-bit counter shares the inputs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [31:0] instr_count;

    logic n_pc_en, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg;
    logic n_reg_write, n_alu_src_a;
    logic [1:0] n_alu_src_b, n_pc_src;
    logic [2:0] n_alu_ctrl;
    logic [3:0] n_count;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
        .instr_count(instr_count)
    );

    multicycle_ctrl #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(n_pc_en), .iord(n_iord), .mem_read(n_mem_read),
        .mem_write(n_mem_write), .ir_write(n_ir_write), .reg_dst(n_reg_dst),
        .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .pc_src(n_pc_src), .alu_ctrl(n_alu_ctrl),
        .instr_count(n_count)
    );

    always #5 clk = ~clk;

    out_t act, act_n;
    assign act   = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl};
    assign act_n = {n_pc_en, n_iord, n_mem_read, n_mem_write, n_ir_write, n_reg_dst,
                    n_mem_to_reg, n_reg_write, n_alu_src_a, n_alu_src_b, n_pc_src, n_alu_ctrl};

    out_t        exp_o;
    logic [31:0] exp_cnt = '0;
    bit          chk_en = 1'b0;
    bit          pending = 1'b0;
    logic [5:0]  nxt_op = '0;
    logic [5:0]  nxt_fn = '0;
    int          checks = 0;
    int          errors = 0;

    // Per-cycle comparison against the model's expectation for this cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL strobes t=%0t op=%b fn=%b got=%h want=%h", $time, opcode, funct, act, exp_o);
            end
            checks++;
            if (act_n !== exp_o) begin
                errors++;
                $display("FAIL strobes_n t=%0t got=%h want=%h", $time, act_n, exp_o);
            end
            checks++;
            if (instr_count !== exp_cnt) begin
                errors++;
                $display("FAIL count t=%0t got=%0d want=%0d", $time, instr_count, exp_cnt);
            end
            checks++;
            if (n_count !== exp_cnt[3:0]) begin
                errors++;
                $display("FAIL count_n t=%0t got=%0d want=%0d", $time, n_count, exp_cnt[3:0]);
            end
        end
    end

    function automatic logic rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic out_t dflt();
        out_t o;
        o = '0;
        o.alu_ctrl = 3'b010;
        return o;
    endfunction

    function automatic out_t fetch_o(input logic r);
        out_t o;
        o = dflt();
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.ir_write  = r;
        o.pc_en     = r;
        return o;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic r_ok(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    // One clock cycle: drive inputs just after the edge and post the expectation.
    task automatic cyc(input out_t e, input logic mr, input logic z);
        @(posedge clk); #1;
        if (pending) begin
            exp_cnt = exp_cnt + 1;
            pending = 1'b0;
        end
        rst       = 1'b1;
        opcode    = nxt_op;
        funct     = nxt_fn;
        mem_ready = mr;
        zero      = z;
        exp_o     = e;
        chk_en    = 1'b1;
    endtask

    task automatic rst_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rst       = 1'b0;
            mem_ready = rb();
            exp_o     = dflt();
            exp_cnt   = '0;
            pending   = 1'b0;
            chk_en    = 1'b1;
        end
    endtask

    // Stall in FETCH so the last retire becomes visible on the counter.
    task automatic stall_cnt(input string nm, input logic [31:0] e);
        cyc(fetch_o(1'b0), 1'b0, rb());
        @(negedge clk); #1;
        lit(nm, instr_count, e);
    endtask

    // Instruction-level model: expands one instruction into its cycle sequence.
    // zs: 0/1 forces zero in the BEQ cycle, 2 picks it at random.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int wf, input int wm, input int zs);
        out_t o;
        logic z;
        nxt_op = op;
        nxt_fn = fn;
        repeat (wf) cyc(fetch_o(1'b0), 1'b0, rb());
        cyc(fetch_o(1'b1), 1'b1, rb());
        o = dflt(); o.alu_src_b = 2'b11;
        cyc(o, rb(), rb());
        case (op)
            6'b000000: begin
                o = dflt(); o.alu_src_a = 1'b1; o.alu_ctrl = r_alu(fn);
                cyc(o, rb(), rb());
                o.reg_dst = 1'b1; o.reg_write = r_ok(fn);
                cyc(o, rb(), rb());
            end
            6'b100011, 6'b101011: begin
                o = dflt(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                cyc(o, rb(), rb());
                o = dflt(); o.iord = 1'b1;
                if (op == 6'b100011) o.mem_read = 1'b1;
                else o.mem_write = 1'b1;
                repeat (wm) cyc(o, 1'b0, rb());
                cyc(o, 1'b1, rb());
                if (op == 6'b100011) begin
                    o = dflt(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                    cyc(o, rb(), rb());
                end
            end
            6'b000100: begin
                z = (zs == 2) ? rb() : (zs == 1);
                o = dflt(); o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110;
                o.pc_src = 2'b01; o.pc_en = z;
                cyc(o, rb(), z);
            end
            6'b001000, 6'b001010: begin
                o = dflt(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_ctrl = (op == 6'b001010) ? 3'b111 : 3'b010;
                cyc(o, rb(), rb());
                o = dflt(); o.reg_write = 1'b1;
                cyc(o, rb(), rb());
            end
            6'b000010: begin
                o = dflt(); o.pc_src = 2'b10; o.pc_en = 1'b1;
                cyc(o, rb(), rb());
            end
            default: ;
        endcase
        pending = 1'b1;
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        out_t o;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b001010, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rst_cycles(3);

        // R-type SUB: write-back cycle carries SUB code and rd write.
        do_instr(6'b000000, 6'b100010, 0, 0, 2);
        @(negedge clk); #1;
        lit("rwb_alu_ctrl", 32'(alu_ctrl), 32'd6);
        lit("rwb_reg_write", 32'(reg_write), 32'd1);
        lit("rwb_reg_dst", 32'(reg_dst), 32'd1);
        stall_cnt("count_after_sub", 32'd1);

        // lw with three wait cycles in MEM_RD.
        do_instr(6'b100011, 6'b000000, 0, 3, 2);
        @(negedge clk); #1;
        lit("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        stall_cnt("count_after_lw", 32'd2);

        // BEQ taken then not taken.
        do_instr(6'b000100, 6'b000000, 0, 0, 1);
        @(negedge clk); #1;
        lit("beq_taken_pc_en", 32'(pc_en), 32'd1);
        lit("beq_pc_src", 32'(pc_src), 32'd1);
        do_instr(6'b000100, 6'b000000, 0, 0, 0);
        @(negedge clk); #1;
        lit("beq_not_taken_pc_en", 32'(pc_en), 32'd0);

        do_instr(6'b001010, 6'b000000, 1, 0, 2);
        do_instr(6'b000010, 6'b000000, 0, 0, 2);
        @(negedge clk); #1;
        lit("j_pc_src", 32'(pc_src), 32'd2);
        lit("j_pc_en", 32'(pc_en), 32'd1);

        // Illegal opcode and illegal funct still retire without writes.
        do_instr(6'b111111, 6'b000000, 0, 0, 2);
        @(negedge clk); #1;
        lit("illegal_reg_write", 32'(reg_write), 32'd0);
        do_instr(6'b000000, 6'b000000, 0, 0, 2);
        @(negedge clk); #1;
        lit("bad_funct_reg_write", 32'(reg_write), 32'd0);
        stall_cnt("count_after_directed", 32'd8);

        // Randomized instruction mix with random memory waits.
        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'b111111) op = 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)]
                                             : 6'($urandom_range(0, 63));
            do_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 2);
        end

        // Reset during a stalled store: the write strobe must drop at once.
        nxt_op = 6'b101011;
        nxt_fn = 6'b000000;
        cyc(fetch_o(1'b1), 1'b1, rb());
        o = dflt(); o.alu_src_b = 2'b11;
        cyc(o, 1'b0, rb());
        o = dflt(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        cyc(o, 1'b0, rb());
        o = dflt(); o.iord = 1'b1; o.mem_write = 1'b1;
        cyc(o, 1'b0, rb());
        @(negedge clk); #1;
        rst     = 1'b0;
        exp_o   = dflt();
        exp_cnt = '0;
        pending = 1'b0;
        #1;
        lit("abort_mem_write", 32'(mem_write), 32'd0);
        lit("abort_iord", 32'(iord), 32'd0);
        lit("abort_count", instr_count, 32'd0);
        rst_cycles(2);

        // Sixteen jumps wrap the 4-bit counter.
        repeat (15) do_instr(6'b000010, 6'b000000, 0, 0, 2);
        cyc(fetch_o(1'b0), 1'b0, rb());
        @(negedge clk); #1;
        lit("narrow_count_15", 32'(n_count), 32'd15);
        do_instr(6'b000010, 6'b000000, 0, 0, 2);
        cyc(fetch_o(1'b0), 1'b0, rb());
        @(negedge clk); #1;
        lit("narrow_count_wrap", 32'(n_count), 32'd0);
        lit("wide_count_16", instr_count, 32'd16);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
